mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one unified, variable-latency memory port between the fetch stage (IF) and the memory stage (DM).
//  Sits between fetch/memory and the single RAM model, in place of their private memories.
//  Serialises requests with data-over-fetch priority plus an anti-starvation guard.
//  Drops fetch responses that are killed by a taken branch (PCSrcM -> if_flush).
// PARAMETERS
//  STARVE_LIMIT  4  consecutive DM grants while IF waits before IF is forced to win
//  CNT_W         3  width of the starvation counter (must hold STARVE_LIMIT)
// PORTS
//  clk        in   1      clock, all state on posedge
//  reset      in   1      synchronous, active-low (0 = reset)
//  if_req     in   1      fetch request; held with if_addr until if_valid or if_flush
//  if_addr    in   WORD   fetch address
//  if_flush   in   1      kill pending/in-flight fetch (branch taken)
//  if_rdata   out  WORD   fetched instruction, valid with if_valid, held after
//  if_valid   out  1      one-cycle pulse: fetch complete
//  dm_req     in   1      data request; held with dm_we/addr/wdata until dm_valid
//  dm_we      in   1      1 = store, 0 = load
//  dm_addr    in   WORD   data address
//  dm_wdata   in   WORD   store data
//  dm_rdata   out  WORD   load data, updated only on load completion
//  dm_valid   out  1      one-cycle pulse: load or store complete
//  mem_req    out  1      registered; high from cycle after grant until ack sampled
//  mem_we     out  1      registered copy of granted write enable
//  mem_addr   out  WORD   registered granted address, stable while mem_req
//  mem_wdata  out  WORD   registered granted store data
//  mem_rdata  in   WORD   memory read data, valid with mem_ack
//  mem_ack    in   1      completion; sampled only while mem_req=1, ignored otherwise
// BEHAVIOUR
//  Reset: state=IDLE; mem_req, mem_we, if_valid, dm_valid, drop, starve_cnt = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
//  FSM: IDLE -> BUSY_D | BUSY_I on grant; BUSY_x -> IDLE on an edge where mem_ack=1.
//  Grant in IDLE: eligible IF = if_req & ~if_flush & ~if_valid; eligible DM = dm_req & ~dm_valid.
//  Priority: DM wins, except IF wins when starve_cnt==STARVE_LIMIT and both are eligible.
//  starve_cnt: increments (saturating) on a DM grant while IF is eligible; clears on any IF grant.
//  Grant edge: latch addr/we/wdata into mem_*; mem_req=1 from the next cycle.
//  Min latency: request in cycle t, mem_req in t+1, ack in t+1 -> valid pulse in t+2.
//  Ack edge: mem_req=0 and state=IDLE.
//    DM: dm_valid=1; dm_rdata<=mem_rdata only if ~mem_we.
//    IF: if_valid=1 and if_rdata<=mem_rdata, unless drop=1 or if_flush=1 in the ack cycle.
//  Valid-pulse cycle: that port is not re-granted (its valid masks eligibility); the other port may be granted.
//    Gives a 1-cycle minimum gap per port.
//  if_flush in BUSY_I: memory transaction still completes (no abort); set drop=1.
//    Ack then yields no if_valid; drop clears on ack.
//  if_flush in IDLE: IF not granted that cycle.
//  if_flush in BUSY_D: no effect on DM.
//  Simultaneous ack and new requests: completion takes effect first; new grant no earlier than next cycle (IDLE).
//  Reset mid-transaction: abandon; mem_req=0 at the reset edge.
//    A late mem_ack is ignored because mem_req=0.
//  mem_addr/mem_we/mem_wdata change only on grant edges.
// STRUCTURE
//  consts.v: `WORD (existing); add arb_state_t enum {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D}.
//  Sub-module mem_arb_prio: combinational grant decision.
//    Inputs: eligibility, starve_cnt. Outputs: grant_i, grant_d.
//  Everything else (FSM, registers, counter) lives in mem_arbiter.
// TESTING
//  1. Lone fetch, addr 0x10, mem acks in 1st mem_req cycle:
//     mem_req @t+1, if_valid @t+2, if_rdata=0x00500093.
//  2. if_req & dm_req (load 0x200) same cycle, 3-cycle memory:
//     DM served first, dm_rdata=0xDEADBEEF, then IF granted in dm_valid cycle.
//  3. Store 0x300<-0x12345678: mem_we=1, mem_wdata=0x12345678; dm_valid pulses; dm_rdata unchanged.
//  4. if_flush 1 cycle after IF grant, ack 2 cycles later:
//     no if_valid; next eligible request granted in ack-following cycle.
//  5. DM requests back-to-back with IF pending:
//     after 4 DM grants IF wins; starve_cnt returns to 0.
//  6. reset=0 while BUSY_D with mem_req high:
//     next cycle mem_req=0, outputs at reset values; late mem_ack produces no dm_valid.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/DM unified memory arbiter.
package mem_arbiter_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational grant decision: data over fetch, unless fetch has starved long enough.
module mem_arb_prio #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             elig_i,
  input  logic             elig_d,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_i,
  output logic             grant_d
);

  logic force_i;

  assign force_i = elig_i && (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_d = elig_d && !force_i;
  assign grant_i = elig_i && !grant_d;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data requests onto one variable-latency memory port,
// dropping fetch responses that a taken branch has killed.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [WORD-1:0] if_addr,
  input  logic            if_flush,
  output logic [WORD-1:0] if_rdata,
  output logic            if_valid,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [WORD-1:0] dm_addr,
  input  logic [WORD-1:0] dm_wdata,
  output logic [WORD-1:0] dm_rdata,
  output logic            dm_valid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata,
  input  logic            mem_ack
);

  arb_state_t       state;
  logic             drop;
  logic [CNT_W-1:0] starve_cnt;
  logic             elig_i;
  logic             elig_d;
  logic             grant_i;
  logic             grant_d;

  // A port's own valid pulse masks it, giving each port a one-cycle gap.
  assign elig_i = if_req && !if_flush && !if_valid;
  assign elig_d = dm_req && !dm_valid;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_prio (
    .elig_i    (elig_i),
    .elig_d    (elig_d),
    .starve_cnt(starve_cnt),
    .grant_i   (grant_i),
    .grant_d   (grant_d)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      if_valid   <= 1'b0;
      dm_rdata   <= '0;
      dm_valid   <= 1'b0;
      drop       <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_d) begin
            state     <= ARB_BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (elig_i && (starve_cnt != CNT_W'(STARVE_LIMIT)))
              starve_cnt <= starve_cnt + 1'b1;
          end else if (grant_i) begin
            state      <= ARB_BUSY_I;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            starve_cnt <= '0;
          end
        end
        ARB_BUSY_I: begin
          // A killed fetch still runs to completion; only its response is discarded.
          if (mem_ack) begin
            state   <= ARB_IDLE;
            mem_req <= 1'b0;
            drop    <= 1'b0;
            if (!drop && !if_flush) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (if_flush) begin
            drop <= 1'b1;
          end
        end
        ARB_BUSY_D: begin
          if (mem_ack) begin
            state    <= ARB_IDLE;
            mem_req  <= 1'b0;
            dm_valid <= 1'b1;
            if (!mem_we) dm_rdata <= mem_rdata;
          end
        end
        default: begin
          state   <= ARB_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for single transactions plus
// hand-written sequences for contention, flush, starvation and reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks   = 0;
  int failures = 0;

  // Memory responder: acks on the lat-th cycle of mem_req, or follows force_ack.
  bit   auto_en   = 1'b1;
  bit   force_ack = 1'b0;
  logic auto_ack  = 1'b0;
  int   lat       = 1;
  int   rcnt      = 0;

  assign mem_ack = auto_en ? auto_ack : force_ack;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_valid (dm_valid),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  function automatic logic [31:0] model(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h0050_0093;
      32'h200: return 32'hDEAD_BEEF;
      default: return {a[15:0], 16'hC0DE};
    endcase
  endfunction

  initial mem_rdata = '0;
  always @(negedge clk) begin
    if (mem_req) begin
      if (rcnt + 1 >= lat) begin
        auto_ack  = 1'b1;
        mem_rdata = model(mem_addr);
        rcnt      = 0;
      end else begin
        auto_ack = 1'b0;
        rcnt     = rcnt + 1;
      end
    end else begin
      auto_ack = 1'b0;
      rcnt     = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout", name);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) return;
    end
    timeout(name);
  endtask

  task automatic wait_valid(input string name, input bit want_dm);
    for (int i = 0; i < 30; i++) begin
      if (want_dm ? dm_valid : if_valid) return;
      @(negedge clk);
    end
    timeout(name);
  endtask

  task automatic clear_inputs();
    if_req   = 1'b0;
    if_addr  = '0;
    if_flush = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    int          lat;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic        exp_dmv;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // dm_rdata entering the table is 0xDEADBEEF from the directed load/store tests.
    vecs[0] = '{1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,         2, 1'b1, 32'h40,  1'b0, 1'b0, 32'h0040_C0DE};
    vecs[1] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h84,  32'h0,         1, 1'b1, 32'h84,  1'b0, 1'b1, 32'h0084_C0DE};
    vecs[2] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h90,  32'hCAFE_F00D, 3, 1'b1, 32'h90,  1'b1, 1'b1, 32'h0084_C0DE};
    vecs[3] = '{1'b1, 32'hA0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,         1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,   32'h0,         1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h10,  32'h0,         4, 1'b1, 32'h10,  1'b0, 1'b1, 32'h0050_0093};
    vecs[6] = '{1'b1, 32'h200,1'b0, 1'b0, 1'b0, 32'h0,   32'h0,         1, 1'b1, 32'h200, 1'b0, 1'b0, 32'hDEAD_BEEF};

    reset = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    chk("rst_mem_req",  {31'b0, mem_req},  32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_dm_valid", {31'b0, dm_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Lone fetch, minimum latency.
    lat = 1; if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("t1_mem_req",  {31'b0, mem_req},  32'd1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_early_v",  {31'b0, if_valid}, 32'd0);
    @(negedge clk);
    chk("t1_if_valid", {31'b0, if_valid}, 32'd1);
    chk("t1_if_rdata", if_rdata, 32'h0050_0093);
    if_req = 1'b0;
    @(negedge clk);
    chk("t1_pulse",    {31'b0, if_valid}, 32'd0);
    chk("t1_req_low",  {31'b0, mem_req},  32'd0);

    // Contention: DM first, IF granted in the dm_valid cycle.
    lat = 3; if_req = 1'b1; if_addr = 32'h44;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    @(negedge clk);
    chk("t2_mem_addr", mem_addr, 32'h200);
    chk("t2_mem_we",   {31'b0, mem_we}, 32'd0);
    wait_valid("t2_dm_wait", 1'b1);
    chk("t2_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk("t2_no_ifv",   {31'b0, if_valid}, 32'd0);
    dm_req = 1'b0;
    @(negedge clk);
    chk("t2_if_req",   {31'b0, mem_req}, 32'd1);
    chk("t2_if_addr",  mem_addr, 32'h44);
    wait_valid("t2_if_wait", 1'b0);
    chk("t2_if_rdata", if_rdata, 32'h0044_C0DE);
    if_req = 1'b0;
    @(negedge clk);

    // Store leaves dm_rdata untouched.
    lat = 2; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("t3_mem_we",    {31'b0, mem_we}, 32'd1);
    chk("t3_mem_wdata", mem_wdata, 32'h1234_5678);
    chk("t3_mem_addr",  mem_addr, 32'h300);
    wait_valid("t3_wait", 1'b1);
    chk("t3_dm_rdata",  dm_rdata, 32'hDEAD_BEEF);
    clear_inputs();
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      lat      = vecs[k].lat;
      if_req   = vecs[k].if_req;
      if_addr  = vecs[k].if_addr;
      if_flush = vecs[k].if_flush;
      dm_req   = vecs[k].dm_req;
      dm_we    = vecs[k].dm_we;
      dm_addr  = vecs[k].dm_addr;
      dm_wdata = vecs[k].dm_wdata;
      @(negedge clk);
      chk($sformatf("vec%0d_req", k), {31'b0, mem_req}, {31'b0, vecs[k].exp_req});
      if (vecs[k].exp_req) begin
        chk($sformatf("vec%0d_addr", k), mem_addr, vecs[k].exp_addr);
        chk($sformatf("vec%0d_we", k), {31'b0, mem_we}, {31'b0, vecs[k].exp_we});
        wait_valid($sformatf("vec%0d_wait", k), vecs[k].exp_dmv);
        if (vecs[k].exp_dmv)
          chk($sformatf("vec%0d_dm_rdata", k), dm_rdata, vecs[k].exp_rdata);
        else
          chk($sformatf("vec%0d_if_rdata", k), if_rdata, vecs[k].exp_rdata);
      end else begin
        @(negedge clk);
        chk($sformatf("vec%0d_still_idle", k), {30'b0, mem_req, if_valid}, 32'd0);
      end
      clear_inputs();
      @(negedge clk);
    end

    // Flush one cycle after IF grant; ack two cycles later; DM then granted.
    lat = 3; if_req = 1'b1; if_addr = 32'h80;
    @(negedge clk);
    chk("t4_mem_addr", mem_addr, 32'h80);
    if_flush = 1'b1; if_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h88;
    @(negedge clk);
    chk("t4_no_ifv_a", {31'b0, if_valid}, 32'd0);
    if_flush = 1'b0;
    @(negedge clk);
    chk("t4_busy",     {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    chk("t4_no_ifv_b", {31'b0, if_valid}, 32'd0);
    chk("t4_req_low",  {31'b0, mem_req},  32'd0);
    @(negedge clk);
    chk("t4_dm_grant", {31'b0, mem_req}, 32'd1);
    chk("t4_dm_addr",  mem_addr, 32'h88);
    wait_valid("t4_dm_wait", 1'b1);
    chk("t4_dm_rdata", dm_rdata, 32'h0088_C0DE);
    chk("t4_no_ifv_c", {31'b0, if_valid}, 32'd0);
    clear_inputs();
    @(negedge clk);

    // Starvation: IF masked by flush during each dm_valid cycle.
    lat = 1; if_req = 1'b1; if_addr = 32'h500;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600;
    for (int k = 1; k <= 4; k++) begin
      wait_req($sformatf("t5_req%0d", k));
      chk($sformatf("t5_dm_addr%0d", k), mem_addr, 32'h600);
      chk($sformatf("t5_cnt%0d", k), 32'(dut.starve_cnt), k);
      wait_valid($sformatf("t5_dmv%0d", k), 1'b1);
      if_flush = 1'b1;
      @(negedge clk);
      if_flush = 1'b0;
    end
    wait_req("t5_if_req");
    chk("t5_if_wins", mem_addr, 32'h500);
    chk("t5_cnt_clr", 32'(dut.starve_cnt), 32'd0);
    wait_valid("t5_if_wait", 1'b0);
    chk("t5_if_rdata", if_rdata, 32'h0500_C0DE);
    clear_inputs();
    @(negedge clk);

    // Reset mid-transaction, then a late ack.
    auto_en = 1'b0; force_ack = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h700;
    @(negedge clk);
    chk("t6_busy", {31'b0, mem_req}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_req_rst",    {31'b0, mem_req}, 32'd0);
    chk("t6_addr_rst",   mem_addr, 32'd0);
    chk("t6_dm_rdata",   dm_rdata, 32'd0);
    chk("t6_if_rdata",   if_rdata, 32'd0);
    reset = 1'b1; dm_req = 1'b0; force_ack = 1'b1;
    @(negedge clk);
    chk("t6_late_ack_a", {30'b0, mem_req, dm_valid}, 32'd0);
    @(negedge clk);
    chk("t6_late_ack_b", {30'b0, mem_req, dm_valid}, 32'd0);
    force_ack = 1'b0; auto_en = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
